hex_display_arbiter: RTL and testbench

Shares the four-digit multiplexed seven-segment display among several requesters (keycode monitor, game-state debug, score, etc.). It accepts 16-bit display values over a valid/ready handshake, selects one requester at a time with round-robin priority, and holds the winner on the display for a guaranteed minimum dwell time. Its `hex_nibble` output feeds the existing four-nibble seven-segment scan driver directly.

---
 rtl/hex_display_arbiter.sv | 109 ++++++++++
 tb/tb_hex_display_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter that lends the four-digit hex display to one requester at a time
// and keeps the winner on screen for a minimum dwell window.
module hex_display_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int DWELL_CYCLES = 50_000_000,
  localparam int PTR_W        = $clog2(NUM_REQ),
  localparam int CNT_W        = $clog2(DWELL_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [3:0]             hex_nibble [4],
  output logic [PTR_W-1:0]       owner,
  output logic                   busy
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  cnt;

  logic              found;
  logic [PTR_W-1:0]  win;
  logic [PTR_W:0]    idx;
  logic              load_en;
  logic [15:0]       load_data;

  // Rotating search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ))
        idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n) begin
      if (state == DWELL)
        req_ready[owner] = 1'b1;
      else if (found)
        req_ready[win] = 1'b1;
    end
  end

  // In IDLE the new winner loads the display; in DWELL only the owner may refresh it.
  always_comb begin
    if (state == IDLE) begin
      load_en   = found;
      load_data = req_data[16*win +: 16];
    end else begin
      load_en   = req_valid[owner];
      load_data = req_data[16*owner +: 16];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      for (int k = 0; k < 4; k++)
        hex_nibble[k] <= 4'h0;
    end else begin
      if (load_en) begin
        for (int k = 0; k < 4; k++)
          hex_nibble[k] <= load_data[4*k +: 4];
      end
      case (state)
        IDLE: begin
          if (found) begin
            owner  <= win;
            rr_ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            cnt    <= CNT_W'(DWELL_CYCLES - 1);
            state  <= DWELL;
            busy   <= 1'b1;
          end
        end
        DWELL: begin
          // Owner refreshes never restart the window; it expires on a fixed count.
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed and randomized bench for hex_display_arbiter against a remaining-dwell reference model.
module tb_hex_display_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DWELL   = 4;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  hex_nibble [4];
  logic [1:0]  owner;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: how many dwell cycles remain, who owns, what is shown.
  int          m_left;
  int          m_owner;
  int          m_rr;
  logic [15:0] m_disp;

  hex_display_arbiter #(.NUM_REQ(NUM_REQ), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .hex_nibble(hex_nibble), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] disp();
    return {hex_nibble[3], hex_nibble[2], hex_nibble[1], hex_nibble[0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_owner = 0; m_rr = 0; m_disp = 16'h0000;
  endtask

  function automatic int model_winner();
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = (m_rr + i) % NUM_REQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    if (!reset_n) return 4'b0000;
    if (m_left > 0) return 4'(1) << m_owner;
    w = model_winner();
    return (w < 0) ? 4'b0000 : 4'(1) << w;
  endfunction

  task automatic model_step();
    int w;
    if (!reset_n) begin
      model_reset();
    end else if (m_left == 0) begin
      w = model_winner();
      if (w >= 0) begin
        m_disp  = req_data[16*w +: 16];
        m_owner = w;
        m_rr    = (w + 1) % NUM_REQ;
        m_left  = DWELL;
      end
    end else begin
      if (req_valid[m_owner]) m_disp = req_data[16*m_owner +: 16];
      m_left--;
    end
  endtask

  task automatic drv(input logic [3:0] v, input logic [63:0] d);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    #1;
    chk("ready", req_ready, exp_ready());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("owner", owner, m_owner);
    chk("busy", busy, m_left > 0);
    chk("disp", disp(), m_disp);
  endtask

  task automatic cyc(input logic [3:0] v, input logic [63:0] d);
    drv(v, d);
    tick();
  endtask

  initial begin
    logic [63:0] rrd;
    rrd = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    reset_n   = 1'b0;
    req_valid = 4'hF;
    req_data  = rrd;
    model_reset();

    // Reset held with every requester valid
    repeat (2) cyc(4'hF, rrd);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_disp", disp(), 16'h0000);
    reset_n = 1'b1;

    // Round-robin with all four requesting continuously
    for (int n = 0; n < 21; n++) begin
      cyc(4'hF, rrd);
      if (n % 5 == 0) begin
        chk("rr_owner", owner, (n / 5) % 4);
        chk("rr_disp", disp(), 16'h1111 * ((n / 5) % 4 + 1));
      end
    end
    repeat (4) cyc(4'h0, rrd);

    // Single grant of 16'hBEEF to requester 2
    drv(4'b0100, {16'h0, 16'hBEEF, 16'h0, 16'h0});
    chk("beef_ready", req_ready, 4'b0100);
    tick();
    chk("beef_owner", owner, 2);
    chk("beef_nib0", hex_nibble[0], 4'hF);
    chk("beef_nib3", hex_nibble[3], 4'hB);
    chk("beef_busy", busy, 1'b1);
    repeat (3) cyc(4'h0, 64'h0);
    chk("beef_busy_last", busy, 1'b1);
    cyc(4'h0, 64'h0);
    chk("beef_idle", busy, 1'b0);

    // Owner refreshes during dwell while requester 3 waits
    cyc(4'b0010, {16'h0, 16'h0, 16'h0001, 16'h0});
    chk("upd_owner", owner, 1);
    drv(4'b1010, {16'hAAAA, 16'h0, 16'h1234, 16'h0});
    chk("upd_ready3", req_ready[3], 1'b0);
    tick();
    chk("upd_disp1", disp(), 16'h1234);
    drv(4'b1010, {16'hAAAA, 16'h0, 16'h5678, 16'h0});
    chk("upd_ready3b", req_ready[3], 1'b0);
    tick();
    chk("upd_disp2", disp(), 16'h5678);
    repeat (2) cyc(4'b1000, {16'hAAAA, 48'h0});
    chk("upd_busy_end", busy, 1'b0);
    cyc(4'b1000, {16'hAAAA, 48'h0});
    chk("upd_grant3", owner, 3);
    chk("upd_disp3", disp(), 16'hAAAA);
    repeat (4) cyc(4'h0, 64'h0);

    // Idle hold with no requests
    for (int n = 0; n < 20; n++) cyc(4'h0, {$urandom, $urandom});
    chk("idle_owner", owner, 3);
    chk("idle_disp", disp(), 16'hAAAA);
    chk("idle_ready", req_ready, 4'b0000);

    // Asynchronous reset two cycles into a dwell window
    cyc(4'b0100, {16'h0, 16'h9999, 32'h0});
    cyc(4'h0, 64'h0);
    cyc(4'h0, 64'h0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_owner", owner, 0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_disp", disp(), 16'h0000);
    chk("arst_ready", req_ready, 4'b0000);
    cyc(4'hF, rrd);
    reset_n = 1'b1;
    cyc(4'hF, rrd);
    chk("post_rst_owner", owner, 0);
    chk("post_rst_disp", disp(), 16'h1111);

    // Randomized traffic
    for (int n = 0; n < 400; n++)
      cyc(4'($urandom_range(0, 15)), {$urandom, $urandom});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
